// File: rtl/reset_seq_monitor.sv
// reset_seq_monitor
// Receiving-end checker for the OTP reset sequence on the 100 kHz oscillator
// domain. After porz releases it expects, in order:
//   rst_otp rise -> {rstz_i2c_reg, rstz_otp_100k} rise together ->
//   otp_rdy rise -> reset_timer_done rise
// with fixed gaps between the steps. It reports either pass or the first
// violation through sticky, registered status outputs.
//
// Timing model: every input is compared against its value from the previous
// posedge (prev_q), so a rise is seen on the first posedge at which the input
// is 1. The status registers update on that same edge, so status is visible
// one cycle after the input is sampled.
//
// gap_cnt counts posedges spent in the current WAIT state. It is cleared on
// arming and on every accepted rise, so on the edge that detects the next rise
// the gap between the two detections is gap_cnt_q + 1. On an error the count
// for the erroring cycle is included and then frozen.

module reset_seq_monitor #(
  parameter int GAP_RSTZ = 3,   // rst_otp rise -> rstz pair rise
  parameter int GAP_RDY  = 4,   // rstz pair rise -> otp_rdy rise
  parameter int GAP_DONE = 4,   // otp_rdy rise -> reset_timer_done rise
  parameter int TOL      = 0,   // allowed +/- deviation on every gap
  parameter int TIMEOUT  = 64   // max cycles waiting for an expected rise (1..255)
) (
  input  logic       clk_osc_100k,
  input  logic       rst,
  input  logic       porz,
  input  logic       rst_otp,
  input  logic       rstz_i2c_reg,
  input  logic       rstz_otp_100k,
  input  logic       otp_rdy,
  input  logic       reset_timer_done,
  output logic       seq_ok,
  output logic       seq_err,
  output logic [2:0] err_code,
  output logic [2:0] err_step,
  output logic [7:0] gap_cnt
);

  // State codes double as the err_step value reported on a violation.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_OTP  = 3'd1,
    ST_WAIT_RSTZ = 3'd2,
    ST_WAIT_RDY  = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_PASS      = 3'd5,
    ST_FAIL      = 3'd6
  } state_e;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_ORDER   = 3'd1;
  localparam logic [2:0] ERR_SPLIT   = 3'd2;
  localparam logic [2:0] ERR_GAP     = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT = 3'd4;
  localparam logic [2:0] ERR_DROP    = 3'd5;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);
  localparam logic [7:0] GAP_SAT   = 8'd255;

  // Bit positions of the observed signals inside the sample vectors.
  localparam int B_OTP  = 0;
  localparam int B_I2C  = 1;
  localparam int B_100K = 2;
  localparam int B_RDY  = 3;
  localparam int B_DONE = 4;

  // Flops and their next-state values.
  state_e     state_q,    state_d;
  logic [4:0] prev_q,     prev_d;
  logic       seq_ok_q,   seq_ok_d;
  logic       seq_err_q,  seq_err_d;
  logic [2:0] err_code_q, err_code_d;
  logic [2:0] err_step_q, err_step_d;
  logic [7:0] gap_cnt_q,  gap_cnt_d;

  // Combinational helpers.
  logic [4:0] cur_s;
  logic [4:0] rise_s;
  logic [7:0] gap_inc_s;
  logic [8:0] gap_len_s;
  logic       exp_rise_s;
  logic       order_s;
  logic       split_s;
  logic       gap_bad_s;
  logic       timeout_s;
  logic       drop_s;
  logic [2:0] err_sel_s;
  logic       any_err_s;

  // True when a measured gap lies inside [nominal - TOL, nominal + TOL].
  function automatic logic gap_in_window(input logic [8:0] gap, input int nominal);
    int g;
    g = int'({23'd0, gap});
    return (g >= (nominal - TOL)) && (g <= (nominal + TOL));
  endfunction

  // Edge detection against last cycle's sample, plus gap arithmetic.
  always_comb begin
    cur_s             = 5'd0;
    cur_s[B_OTP]      = rst_otp;
    cur_s[B_I2C]      = rstz_i2c_reg;
    cur_s[B_100K]     = rstz_otp_100k;
    cur_s[B_RDY]      = otp_rdy;
    cur_s[B_DONE]     = reset_timer_done;
    rise_s            = cur_s & ~prev_q;
    prev_d            = cur_s;
    gap_inc_s         = (gap_cnt_q == GAP_SAT) ? GAP_SAT : (gap_cnt_q + 8'd1);
    gap_len_s         = {1'b0, gap_cnt_q} + 9'd1;
  end

  // Per-state classification of this cycle's activity into expected rise and
  // the individual violation kinds.
  always_comb begin
    exp_rise_s = 1'b0;
    order_s    = 1'b0;
    split_s    = 1'b0;
    gap_bad_s  = 1'b0;
    drop_s     = 1'b0;
    case (state_q)
      ST_WAIT_OTP: begin
        // Signals high at arming never produce a rise, so a pre-high
        // rst_otp simply runs into the timeout.
        exp_rise_s = rise_s[B_OTP];
        order_s    = |rise_s[B_DONE:B_I2C];
      end
      ST_WAIT_RSTZ: begin
        exp_rise_s = rise_s[B_I2C] & rise_s[B_100K];
        split_s    = rise_s[B_I2C] ^ rise_s[B_100K];
        order_s    = rise_s[B_RDY] | rise_s[B_DONE];
        gap_bad_s  = exp_rise_s & ~gap_in_window(gap_len_s, GAP_RSTZ);
        drop_s     = ~cur_s[B_OTP];
      end
      ST_WAIT_RDY: begin
        exp_rise_s = rise_s[B_RDY];
        order_s    = rise_s[B_DONE];
        gap_bad_s  = exp_rise_s & ~gap_in_window(gap_len_s, GAP_RDY);
        drop_s     = ~(&cur_s[B_100K:B_OTP]);
      end
      ST_WAIT_DONE: begin
        exp_rise_s = rise_s[B_DONE];
        gap_bad_s  = exp_rise_s & ~gap_in_window(gap_len_s, GAP_DONE);
        drop_s     = ~(&cur_s[B_RDY:B_OTP]);
      end
      default: begin
        exp_rise_s = 1'b0;
      end
    endcase
  end

  // Timeout only counts when no expected rise arrives in the same cycle.
  always_comb begin
    timeout_s = 1'b0;
    case (state_q)
      ST_WAIT_OTP, ST_WAIT_RSTZ, ST_WAIT_RDY, ST_WAIT_DONE: begin
        timeout_s = ~exp_rise_s & (gap_inc_s >= TIMEOUT_C);
      end
      default: begin
        timeout_s = 1'b0;
      end
    endcase
  end

  // Several violations in one cycle report the lowest code.
  always_comb begin
    err_sel_s = ERR_NONE;
    if (order_s) begin
      err_sel_s = ERR_ORDER;
    end else if (split_s) begin
      err_sel_s = ERR_SPLIT;
    end else if (gap_bad_s) begin
      err_sel_s = ERR_GAP;
    end else if (timeout_s) begin
      err_sel_s = ERR_TIMEOUT;
    end else if (drop_s) begin
      err_sel_s = ERR_DROP;
    end else begin
      err_sel_s = ERR_NONE;
    end
    any_err_s = (err_sel_s != ERR_NONE);
  end

  // State register.
  always_ff @(posedge clk_osc_100k) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: porz low aborts ahead of any error, FAIL only leaves on rst.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        state_d = porz ? ST_WAIT_OTP : ST_IDLE;
      end
      ST_WAIT_OTP, ST_WAIT_RSTZ, ST_WAIT_RDY, ST_WAIT_DONE: begin
        if (!porz) begin
          state_d = ST_IDLE;
        end else if (any_err_s) begin
          state_d = ST_FAIL;
        end else if (exp_rise_s) begin
          state_d = state_e'(state_q + 3'd1);
        end else begin
          state_d = state_q;
        end
      end
      ST_PASS: begin
        state_d = porz ? ST_PASS : ST_IDLE;
      end
      ST_FAIL: begin
        state_d = ST_FAIL;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Status next values: counting, error latching and abort clearing.
  always_comb begin
    seq_ok_d   = seq_ok_q;
    seq_err_d  = seq_err_q;
    err_code_d = err_code_q;
    err_step_d = err_step_q;
    gap_cnt_d  = gap_cnt_q;
    case (state_q)
      ST_IDLE: begin
        seq_ok_d  = 1'b0;
        gap_cnt_d = 8'd0;
      end
      ST_WAIT_OTP, ST_WAIT_RSTZ, ST_WAIT_RDY, ST_WAIT_DONE: begin
        if (!porz) begin
          seq_ok_d  = 1'b0;
          gap_cnt_d = 8'd0;
        end else if (any_err_s) begin
          seq_err_d  = 1'b1;
          err_code_d = err_sel_s;
          err_step_d = state_q;
          gap_cnt_d  = gap_inc_s;
        end else if (exp_rise_s) begin
          seq_ok_d  = (state_q == ST_WAIT_DONE);
          gap_cnt_d = 8'd0;
        end else begin
          gap_cnt_d = gap_inc_s;
        end
      end
      ST_PASS: begin
        if (!porz) begin
          seq_ok_d  = 1'b0;
          gap_cnt_d = 8'd0;
        end else begin
          seq_ok_d  = 1'b1;
        end
      end
      ST_FAIL: begin
        gap_cnt_d = gap_cnt_q;
      end
      default: begin
        seq_ok_d  = 1'b0;
        gap_cnt_d = 8'd0;
      end
    endcase
  end

  // Status and previous-sample registers.
  always_ff @(posedge clk_osc_100k) begin
    if (rst) begin
      prev_q     <= 5'd0;
      seq_ok_q   <= 1'b0;
      seq_err_q  <= 1'b0;
      err_code_q <= ERR_NONE;
      err_step_q <= 3'd0;
      gap_cnt_q  <= 8'd0;
    end else begin
      prev_q     <= prev_d;
      seq_ok_q   <= seq_ok_d;
      seq_err_q  <= seq_err_d;
      err_code_q <= err_code_d;
      err_step_q <= err_step_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  assign seq_ok   = seq_ok_q;
  assign seq_err  = seq_err_q;
  assign err_code = err_code_q;
  assign err_step = err_step_q;
  assign gap_cnt  = gap_cnt_q;

endmodule
